pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STAGES, default 6, SHALL give the stall vector width: bit0 = PC, bit1 = IF/ID, bit2 = ID/EX, bit3 = EX/MEM, and so on; legal values are 4 or more.
REQ-002 Parameter CNT_W, default 5, SHALL give the width of the multi-cycle stall counter.
REQ-003 Parameter AW, default 32, SHALL give the width of the flush target address.
REQ-004 Parameter EX_STAGE, default 3, SHALL give the stage index whose stall mask is applied during multi-cycle operations; it must be less than STAGES.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 stallreq_stage  in  STAGES  bit k high means stage k requests a stall this cycle.
REQ-009 stallreq_bubble  in  1  upstream-only stall request from ID (hold IF/ID only).
REQ-010 mc_start  in  1  a multi-cycle EX operation begins this cycle.
REQ-011 mc_cycles  in  CNT_W  total stall length N of that operation, sampled with mc_start.
REQ-012 flush_req  in  1  pipeline flush request (exception, eret, mispredict).
REQ-013 flush_pc  in  AW  redirect address, sampled with flush_req.
REQ-014 stall  out  STAGES  per-stage hold vector.
REQ-015 flush  out  1  one-cycle registered flush pulse.
REQ-016 new_pc  out  AW  registered redirect address.
REQ-017 mc_busy  out  1  high while in state MC.

Function
REQ-018 The request mask SHALL be computed as follows:
- If k is the highest set bit of stallreq_stage, bits [k:0] = 1 and all others = 0.
- Otherwise, if stallreq_bubble is high, only bit1 = 1.
- Otherwise, all bits = 0.
REQ-019 The EX mask SHALL have bits [EX_STAGE:0] = 1.
REQ-020 The FSM SHALL have states IDLE, MC and FLUSH, and SHALL enter IDLE on reset.
REQ-021 In IDLE, stall SHALL be the request mask, ORed with the EX mask in any cycle where mc_start=1 and N>=1.
REQ-022 In IDLE with mc_start=1 and flush_req=0, the block SHALL act on N as follows:
- N>=2: load the counter with N-1 and go to MC.
- N=1: stall for that single cycle and stay in IDLE.
- N=0: ignore mc_start.
REQ-023 In MC, stall SHALL be the EX mask ORed with the request mask, and the counter SHALL decrement each cycle.
REQ-024 In MC, the FSM SHALL return to IDLE at the edge where the counter equals 1, so stall stays asserted for exactly N consecutive cycles starting with the mc_start cycle.
REQ-025 mc_start SHALL be ignored while in MC or FLUSH.
REQ-026 flush_req=1 in any state SHALL, at the next edge:
- go to FLUSH,
- register flush=1 and new_pc=flush_pc,
- clear the counter.
REQ-027 flush_req SHALL take priority over mc_start in the same cycle, and SHALL abort MC.
REQ-028 In FLUSH, stall SHALL be all zeros regardless of requests, and flush SHALL be 1.
REQ-029 From FLUSH, the next state SHALL be FLUSH if flush_req=1 (back-to-back flush, new_pc reloaded), else IDLE.
REQ-030 flush SHALL be high only in FLUSH, and new_pc SHALL hold its last value otherwise.
REQ-031 In the cycle flush_req is first asserted, stall SHALL still follow the state rules; the flush takes effect one cycle later.
REQ-032 mc_busy SHALL be registered and equal to (state == MC).

Reset
REQ-033 While rst=1, stall SHALL be forced to all zeros combinationally.
REQ-034 At an edge where rst=1, the block SHALL set state=IDLE, counter=0, flush=0, new_pc=0 and mc_busy=0, overriding flush_req and mc_start.
REQ-035 Reset asserted during MC or FLUSH SHALL abort the operation with no residual stall or flush after release.

Verification
REQ-036 Priority encode: with STAGES=6:
- stallreq_stage=6'b001000 -> stall=6'b001111.
- stallreq_bubble alone -> 6'b000010.
- bubble + stallreq_stage=6'b000010 -> 6'b000011.
- 6'b100001 -> 6'b111111.
REQ-037 Multi-cycle: mc_start=1, mc_cycles=4 at cycle t ->
- stall=6'b001111 in cycles t..t+3,
- mc_busy=1 in t+1..t+3,
- stall=6'b000000 at t+4.
The same stimulus with mc_cycles=1 -> stall only at t; mc_cycles=0 -> no stall.
REQ-038 Flush abort: during MC, flush_req=1, flush_pc=32'h0000_0180 at cycle t ->
- at t+1: flush=1, new_pc=32'h180, stall=0, mc_busy=0;
- at t+2: flush=0, IDLE.
REQ-039 Simultaneous requests: flush_req and mc_start (N=5) in the same cycle -> MC never entered, FLUSH next cycle. Back-to-back flush_req with pc 0x100 then 0x200 -> flush high two cycles, new_pc 0x100 then 0x200.
REQ-040 Reset mid-MC: rst=1 at MC counter=3 with stallreq_stage=6'b000100 -> stall=0 while rst is high; after release, mc_busy=0 and stall follows requests only.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall vector from priority-encoded requests,
// multi-cycle EX stall sequencing and a registered one-cycle flush/redirect.
module pipe_ctrl #(
  parameter int STAGES   = 6,
  parameter int CNT_W    = 5,
  parameter int AW       = 32,
  parameter int EX_STAGE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq_stage,
  input  logic              stallreq_bubble,
  input  logic              mc_start,
  input  logic [CNT_W-1:0]  mc_cycles,
  input  logic              flush_req,
  input  logic [AW-1:0]     flush_pc,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [AW-1:0]     new_pc,
  output logic              mc_busy,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MC    = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flush_q, flush_d;
  logic [AW-1:0]     new_pc_q, new_pc_d;
  logic              mc_busy_q, mc_busy_d;

  logic [STAGES-1:0] req_mask;
  logic [STAGES-1:0] ex_mask;
  logic              any_req;
  logic              mc_go;

  // A stall at stage k must also hold every stage upstream of it.
  always_comb begin
    any_req  = 1'b0;
    req_mask = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      any_req     = any_req | stallreq_stage[i];
      req_mask[i] = any_req;
    end
    if (!any_req && stallreq_bubble) req_mask[1] = 1'b1;
  end

  always_comb begin
    ex_mask = '0;
    for (int i = 0; i < STAGES; i++) begin
      ex_mask[i] = (i <= EX_STAGE);
    end
  end

  assign mc_go = mc_start && (mc_cycles != '0);

  always_comb begin
    stall = '0;
    if (!rst) begin
      case (state_q)
        IDLE:    stall = mc_go ? (req_mask | ex_mask) : req_mask;
        MC:      stall = req_mask | ex_mask;
        default: stall = '0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_pc_d = new_pc_q;
    if (flush_req) begin
      state_d  = FLUSH;
      cnt_d    = '0;
      new_pc_d = flush_pc;
    end else begin
      case (state_q)
        IDLE: begin
          // N=1 is covered entirely by the combinational stall in this cycle.
          if (mc_start && mc_cycles > CNT_W'(1)) begin
            state_d = MC;
            cnt_d   = mc_cycles - CNT_W'(1);
          end
        end
        MC: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    flush_d   = (state_d == FLUSH);
    mc_busy_d = (state_d == MC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      flush_q   <= 1'b0;
      new_pc_q  <= '0;
      mc_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush_d;
      new_pc_q  <= new_pc_d;
      mc_busy_q <= mc_busy_d;
    end
  end

  assign flush     = flush_q;
  assign new_pc    = new_pc_q;
  assign mc_busy   = mc_busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a table of per-cycle stimulus with hand-derived expected outputs,
// then random priority-encode vectors checked against an independent encoder.
module tb_pipe_ctrl;

  localparam int W = 6 + 1 + 32 + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stallreq_stage;
  logic        stallreq_bubble;
  logic        mc_start;
  logic [4:0]  mc_cycles;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic [5:0]  stage;
    logic        bubble;
    logic        mcs;
    logic [4:0]  n;
    logic        fr;
    logic [31:0] fpc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  pipe_ctrl #(.STAGES(6), .CNT_W(5), .AW(32), .EX_STAGE(3)) dut (
    .clk(clk), .rst(rst), .stallreq_stage(stallreq_stage),
    .stallreq_bubble(stallreq_bubble), .mc_start(mc_start), .mc_cycles(mc_cycles),
    .flush_req(flush_req), .flush_pc(flush_pc), .stall(stall), .flush(flush),
    .new_pc(new_pc), .mc_busy(mc_busy), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [5:0] s, input logic b,
                              input logic m, input logic [4:0] n, input logic f,
                              input logic [31:0] p, input logic [5:0] es,
                              input logic ef, input logic [31:0] ep, input logic eb);
    vec_t v;
    v.rst = r; v.stage = s; v.bubble = b; v.mcs = m; v.n = n; v.fr = f; v.fpc = p;
    v.e_stall = es; v.e_flush = ef; v.e_pc = ep; v.e_busy = eb;
    return v;
  endfunction

  // Driver: inputs change just after the rising edge, outputs are compared at the falling edge.
  task automatic drive_check(input vec_t v, input string name);
    logic [W-1:0] got, exp;
    rst = v.rst; stallreq_stage = v.stage; stallreq_bubble = v.bubble;
    mc_start = v.mcs; mc_cycles = v.n; flush_req = v.fr; flush_pc = v.fpc;
    exp_q.push_back({v.e_stall, v.e_flush, v.e_pc, v.e_busy});
    @(negedge clk);
    got = {stall, flush, new_pc, mc_busy};
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got stall=%b flush=%b new_pc=%h busy=%b, want stall=%b flush=%b new_pc=%h busy=%b",
               name, got[39:34], got[33], got[32:1], got[0],
               exp[39:34], exp[33], exp[32:1], exp[0]);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] ref_mask(input logic [5:0] s, input logic b);
    logic [5:0] m;
    int k;
    k = -1;
    for (int i = 0; i < 6; i++) if (s[i]) k = i;
    if (k >= 0) m = 6'((7'd2 << k) - 7'd1);
    else        m = b ? 6'b000010 : 6'b000000;
    return m;
  endfunction

  initial begin
    rst = 1'b1; stallreq_stage = '0; stallreq_bubble = 1'b0; mc_start = 1'b0;
    mc_cycles = '0; flush_req = 1'b0; flush_pc = '0;
    repeat (2) @(posedge clk);
    #1;

    //              rst stage      bub mcs n      fr  fpc       | stall      fl  pc        busy
    tbl.push_back(mk(1, 6'b111111, 1, 1, 5'd4, 1, 32'h55,  6'b000000, 0, 32'h0,   0)); // reset row
    tbl.push_back(mk(0, 6'b000000, 0, 0, 5'd0, 0, 32'h0,   6'b000000, 0, 32'h0,   0));
    tbl.push_back(mk(0, 6'b001000, 0, 0, 5'd0, 0, 32'h0,   6'b001111, 0, 32'h0,   0));
    tbl.push_back(mk(0, 6'b000000, 1, 0, 5'd0, 0, 32'h0,   6'b000010, 0, 32'h0,   0));
    tbl.push_back(mk(0, 6'b000010, 1, 0, 5'd0, 0, 32'h0,   6'b000011, 0, 32'h0,   0));
    tbl.push_back(mk(0, 6'b100001, 0, 0, 5'd0, 0, 32'h0,   6'b111111, 0, 32'h0,   0));
    tbl.push_back(mk(0, 6'b000001, 0, 0, 5'd0, 0, 32'h0,   6'b000001, 0, 32'h0,   0));
    // multi-cycle N=4 (second mc_start ignored while in MC)
    tbl.push_back(mk(0, 6'b000000, 0, 1, 5'd4, 0, 32'h0,   6'b001111, 0, 32'h0,   0));
    tbl.push_back(mk(0, 6'b000000, 0, 0, 5'd0, 0, 32'h0,   6'b001111, 0, 32'h0,   1));
    tbl.push_back(mk(0, 6'b100000, 0, 1, 5'd2, 0, 32'h0,   6'b111111, 0, 32'h0,   1));
    tbl.push_back(mk(0, 6'b000000, 0, 0, 5'd0, 0, 32'h0,   6'b001111, 0, 32'h0,   1));
    tbl.push_back(mk(0, 6'b000000, 0, 0, 5'd0, 0, 32'h0,   6'b000000, 0, 32'h0,   0));
    // N=1 and N=0
    tbl.push_back(mk(0, 6'b000000, 0, 1, 5'd1, 0, 32'h0,   6'b001111, 0, 32'h0,   0));
    tbl.push_back(mk(0, 6'b000000, 0, 0, 5'd0, 0, 32'h0,   6'b000000, 0, 32'h0,   0));
    tbl.push_back(mk(0, 6'b000000, 0, 1, 5'd0, 0, 32'h0,   6'b000000, 0, 32'h0,   0));
    tbl.push_back(mk(0, 6'b000000, 0, 0, 5'd0, 0, 32'h0,   6'b000000, 0, 32'h0,   0));
    tbl.push_back(mk(0, 6'b000000, 1, 1, 5'd0, 0, 32'h0,   6'b000010, 0, 32'h0,   0));
    // flush aborts MC
    tbl.push_back(mk(0, 6'b000000, 0, 1, 5'd6, 0, 32'h0,   6'b001111, 0, 32'h0,   0));
    tbl.push_back(mk(0, 6'b000000, 0, 0, 5'd0, 0, 32'h0,   6'b001111, 0, 32'h0,   1));
    tbl.push_back(mk(0, 6'b000010, 0, 0, 5'd0, 1, 32'h180, 6'b001111, 0, 32'h0,   1));
    tbl.push_back(mk(0, 6'b111111, 0, 0, 5'd0, 0, 32'h0,   6'b000000, 1, 32'h180, 0));
    tbl.push_back(mk(0, 6'b000000, 0, 0, 5'd0, 0, 32'h0,   6'b000000, 0, 32'h180, 0));
    // flush beats mc_start, then back-to-back flush
    tbl.push_back(mk(0, 6'b000000, 0, 1, 5'd5, 1, 32'h100, 6'b001111, 0, 32'h180, 0));
    tbl.push_back(mk(0, 6'b000000, 0, 0, 5'd0, 1, 32'h200, 6'b000000, 1, 32'h100, 0));
    tbl.push_back(mk(0, 6'b000000, 0, 1, 5'd5, 0, 32'h0,   6'b000000, 1, 32'h200, 0));
    tbl.push_back(mk(0, 6'b000000, 0, 0, 5'd0, 0, 32'h0,   6'b000000, 0, 32'h200, 0));
    // reset mid-MC at counter=3
    tbl.push_back(mk(0, 6'b000000, 0, 1, 5'd6, 0, 32'h0,   6'b001111, 0, 32'h200, 0));
    tbl.push_back(mk(0, 6'b000000, 0, 0, 5'd0, 0, 32'h0,   6'b001111, 0, 32'h200, 1));
    tbl.push_back(mk(0, 6'b000000, 0, 0, 5'd0, 0, 32'h0,   6'b001111, 0, 32'h200, 1));
    tbl.push_back(mk(1, 6'b000100, 0, 0, 5'd0, 0, 32'h0,   6'b000000, 0, 32'h200, 1));
    tbl.push_back(mk(0, 6'b000100, 0, 0, 5'd0, 0, 32'h0,   6'b000111, 0, 32'h0,   0));
    tbl.push_back(mk(0, 6'b000000, 0, 0, 5'd0, 0, 32'h0,   6'b000000, 0, 32'h0,   0));
    // reset during FLUSH overrides a pending flush_req
    tbl.push_back(mk(0, 6'b000000, 0, 0, 5'd0, 1, 32'h3c,  6'b000000, 0, 32'h0,   0));
    tbl.push_back(mk(1, 6'b000000, 0, 1, 5'd3, 1, 32'h77,  6'b000000, 1, 32'h3c,  0));
    tbl.push_back(mk(0, 6'b000000, 0, 0, 5'd0, 0, 32'h0,   6'b000000, 0, 32'h0,   0));
    // shortest MC, N=2
    tbl.push_back(mk(0, 6'b000000, 0, 1, 5'd2, 0, 32'h0,   6'b001111, 0, 32'h0,   0));
    tbl.push_back(mk(0, 6'b000000, 0, 0, 5'd0, 0, 32'h0,   6'b001111, 0, 32'h0,   1));
    tbl.push_back(mk(0, 6'b000000, 0, 0, 5'd0, 0, 32'h0,   6'b000000, 0, 32'h0,   0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive_check(tbl[i], $sformatf("row%0d", i));
    end

    // random priority-encode vectors from IDLE
    for (int i = 0; i < 24; i++) begin
      logic [5:0] s;
      logic       b;
      s = 6'($urandom_range(0, 63));
      if (i % 4 == 0) s = 6'b000000;
      b = 1'($urandom_range(0, 1));
      drive_check(mk(0, s, b, 0, 5'd0, 0, 32'h0, ref_mask(s, b), 0, 32'h0, 0),
                  $sformatf("rand%0d", i));
    end

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
